// File: rtl/uart_tx_line_arbiter.sv
// Round-robin arbiter that grants one text-line producer at a time and streams
// its latched line byte by byte (MSB byte first) into uart_tx_only under ready.
module uart_tx_line_arbiter #(
  parameter int N_REQ    = 2,
  parameter int LINE_LEN = 34,
  parameter int LW       = $clog2(LINE_LEN + 1)
) (
  input  logic                       i_clk_20mhz,
  input  logic                       i_rstn_20mhz,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*LINE_LEN*8-1:0] i_req_line,
  input  logic [N_REQ*LW-1:0]        i_req_len,
  output logic [N_REQ-1:0]           o_req_done,
  output logic [N_REQ-1:0]           o_grant,
  output logic                       o_busy,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_valid,
  input  logic                       i_tx_ready
);

  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LB = LINE_LEN * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [RW-1:0]     rr_r, rr_s, gidx_r, gidx_s;
  logic [N_REQ-1:0]  grant_r, grant_s, done_r, done_s;
  logic [7:0]        data_r, data_s;
  logic [LB-1:0]     line_r, line_s;
  logic [LW-1:0]     len_r, len_s, idx_r, idx_s;

  logic              found_s;
  logic [RW-1:0]     sel_s;
  logic [LB-1:0]     sel_line_s;
  logic [LW-1:0]     sel_len_s, eff_len_s;

  // Byte idx of a line, counting down from the most significant byte.
  function automatic logic [7:0] line_byte(input logic [LB-1:0] line, input logic [LW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < LINE_LEN; i++) begin
      if (idx == LW'(i)) begin
        b = line[(LINE_LEN-1-i)*8 +: 8];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // Round-robin pick: first valid requester at or after the rr pointer, wrapping.
  always_comb begin
    logic [RW:0] cand;
    found_s    = 1'b0;
    sel_s      = '0;
    sel_line_s = '0;
    sel_len_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_r} + (RW+1)'(i);
      if (cand >= (RW+1)'(N_REQ)) begin
        cand = cand - (RW+1)'(N_REQ);
      end else begin
        cand = cand;
      end
      if (!found_s && i_req_valid[RW'(cand)]) begin
        found_s = 1'b1;
        sel_s   = RW'(cand);
      end else begin
        found_s = found_s;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_s == RW'(k)) begin
        sel_line_s = i_req_line[k*LB +: LB];
        sel_len_s  = i_req_len[k*LW +: LW];
      end else begin
        sel_len_s  = sel_len_s;
      end
    end
    eff_len_s = (sel_len_s > LW'(LINE_LEN)) ? LW'(LINE_LEN) : sel_len_s;
  end

  // Next-state and datapath updates for the grant/send/done sequence.
  always_comb begin
    state_s = state_r;
    rr_s    = rr_r;
    gidx_s  = gidx_r;
    grant_s = grant_r;
    done_s  = '0;
    data_s  = data_r;
    line_s  = line_r;
    len_s   = len_r;
    idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          gidx_s  = sel_s;
          grant_s = N_REQ'(1) << sel_s;
          line_s  = sel_line_s;
          len_s   = eff_len_s;
          idx_s   = '0;
          data_s  = line_byte(sel_line_s, '0);
          if (eff_len_s != '0) begin
            state_s = ST_SEND;
          end else begin
            state_s = ST_DONE;
            done_s  = N_REQ'(1) << sel_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        // Data only advances on an accepted byte, so a stall holds the current byte.
        if (i_tx_ready) begin
          idx_s = idx_r + LW'(1);
          if (idx_r == len_r - LW'(1)) begin
            state_s = ST_DONE;
            done_s  = grant_r;
          end else begin
            data_s = line_byte(line_r, idx_r + LW'(1));
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        grant_s = '0;
        rr_s    = (gidx_r == RW'(N_REQ-1)) ? '0 : gidx_r + RW'(1);
        state_s = ST_IDLE;
      end
      default: begin
        grant_s = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_r <= ST_IDLE;
      rr_r    <= '0;
      gidx_r  <= '0;
      grant_r <= '0;
      done_r  <= '0;
      data_r  <= 8'h00;
      line_r  <= '0;
      len_r   <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_s;
      rr_r    <= rr_s;
      gidx_r  <= gidx_s;
      grant_r <= grant_s;
      done_r  <= done_s;
      data_r  <= data_s;
      line_r  <= line_s;
      len_r   <= len_s;
      idx_r   <= idx_s;
    end
  end

  assign o_grant    = grant_r;
  assign o_req_done = done_r;
  assign o_tx_data  = data_r;
  assign o_busy     = (state_r != ST_IDLE);
  assign o_tx_valid = (state_r == ST_SEND) && i_tx_ready;

endmodule
